// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: register map,
// control bit positions, blanking constants, hex decoder and scan states.
package seven_seg_pkg;

    localparam logic [2:0] OFS_DIG0 = 3'd0;
    localparam logic [2:0] OFS_DIG1 = 3'd1;
    localparam logic [2:0] OFS_DIG2 = 3'd2;
    localparam logic [2:0] OFS_DIG3 = 3'd3;
    localparam logic [2:0] OFS_DP   = 3'd4;
    localparam logic [2:0] OFS_EN   = 3'd5;
    localparam logic [2:0] OFS_CTRL = 3'd6;

    localparam logic [7:0] WINDOW_SIZE = 8'd7;

    localparam int unsigned CTRL_ON_BIT  = 0;
    localparam int unsigned CTRL_RAW_BIT = 1;

    localparam logic [3:0] SEL_OFF   = 4'hF;
    localparam logic [7:0] DIGIT_OFF = 8'hFF;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

    // Active-low gfedcba pattern for a hex nibble; the dp bit is added by the caller.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_regs.sv
// Bus address decode and register file for the scan controller:
// four digit registers, decimal-point mask, digit-enable mask and control bits.
module seven_seg_regs
    import seven_seg_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hD0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [7:0]      i_addr,
    input  logic [7:0]      i_data,
    input  logic            i_we,
    output logic [3:0][7:0] o_dig,
    output logic [3:0]      o_dp,
    output logic [3:0]      o_en,
    output logic            o_on,
    output logic            o_raw
);

    logic [3:0][7:0] r_dig;
    logic [3:0]      r_dp;
    logic [3:0]      r_en;
    logic [1:0]      r_ctrl;

    logic [7:0] w_ofs;
    logic       w_hit;

    // Addresses below the base wrap to large offsets, so one compare covers both ends.
    assign w_ofs = i_addr - BASE_ADDR;
    assign w_hit = i_we && (w_ofs < WINDOW_SIZE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dig  <= '0;
            r_dp   <= '0;
            r_en   <= 4'hF;
            r_ctrl <= 2'b01;
        end else if (w_hit) begin
            case (w_ofs[2:0])
                OFS_DIG0, OFS_DIG1, OFS_DIG2, OFS_DIG3: r_dig[w_ofs[1:0]] <= i_data;
                OFS_DP:   r_dp   <= i_data[3:0];
                OFS_EN:   r_en   <= i_data[3:0];
                OFS_CTRL: r_ctrl <= {i_data[CTRL_RAW_BIT], i_data[CTRL_ON_BIT]};
                default:  ;
            endcase
        end
    end

    assign o_dig = r_dig;
    assign o_dp  = r_dp;
    assign o_en  = r_en;
    assign o_on  = r_ctrl[0];
    assign o_raw = r_ctrl[1];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller with a bus-mapped
// register file, programmable dwell, anti-ghosting blank gap and registered outputs.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR    = 8'hD0,
    parameter int unsigned SCAN_DIV     = 2500,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic [3:0] SEL,
    output logic [7:0] DIGIT
);

    localparam int unsigned CNT_MAX0 = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    // With no blank gap, slots run back to back and BLANK is only seen out of reset.
    localparam scan_state_t ST_AFTER_SHOW = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    logic [3:0][7:0] w_dig;
    logic [3:0]      w_dp;
    logic [3:0]      w_en;
    logic            w_on;
    logic            w_raw;

    scan_state_t     r_state;
    scan_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]      r_idx;
    logic [1:0]      w_idx_nxt;

    logic [7:0]      w_cur_dig;
    logic [3:0]      w_sel_nxt;
    logic [7:0]      w_digit_nxt;

    seven_seg_regs #(
        .BASE_ADDR (BASE_ADDR)
    ) u_regs (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_addr (BUS_ADDR),
        .i_data (BUS_DATA),
        .i_we   (BUS_WE),
        .o_dig  (w_dig),
        .o_dp   (w_dp),
        .o_en   (w_en),
        .o_on   (w_on),
        .o_raw  (w_raw)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Display-off is checked before any slot boundary so a disable always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        if (!w_on) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_AFTER_SHOW;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
                ST_BLANK: begin
                    if ((BLANK_CYCLES == 0) || (r_cnt == BLANK_LAST)) begin
                        w_state_nxt = ST_SHOW;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_state_nxt = ST_AFTER_SHOW;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = r_idx + 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    assign w_cur_dig = w_dig[r_idx];

    always_comb begin
        w_sel_nxt   = SEL_OFF;
        w_digit_nxt = DIGIT_OFF;
        if (w_on && (r_state == ST_SHOW) && w_en[r_idx]) begin
            w_sel_nxt   = ~(4'b0001 << r_idx);
            w_digit_nxt = w_raw ? w_cur_dig : {~w_dp[r_idx], hex_to_seg(w_cur_dig[3:0])};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            SEL   <= SEL_OFF;
            DIGIT <= DIGIT_OFF;
        end else begin
            SEL   <= w_sel_nxt;
            DIGIT <= w_digit_nxt;
        end
    end

endmodule
